ans_bit_unpacker: RTL
=====================

// Module: ans_bit_unpacker
// PURPOSE
//  Upstream neighbour of ans_decoder. Accepts the compressed stream as bytes
//  from the pin interface and serves variable-length bit fields (1..MAX_READ
//  bits, MSB-first) on request. ans_decoder uses these fields for state
//  initialisation and renormalisation reads.
//  Single clock domain; valid/ready on both sides; gated by the global en.
// PARAMETERS
//  BUF_W     32  bit-buffer depth in bits; must be >= MAX_READ+8
//  MAX_READ  16  widest field per request; rd_data width
//  LEN_W     5   width of rd_len; must satisfy 2**LEN_W > MAX_READ
// PORTS
//  clk       in   1         clock, rising edge
//  rst_n     in   1         reset, asynchronous, active-low
//  en        in   1         global enable; no state changes while 0
//  byte_in   in   8         stream byte, first-arriving bit = byte_in[7]
//  byte_vld  in   1         byte_in valid
//  byte_rdy  out  1         unpacker accepts a byte this cycle
//  rd_len    in   LEN_W     requested bit count, legal range 1..MAX_READ
//  rd_vld    in   1         read request valid
//  rd_rdy    out  1         request accepted this cycle
//  rd_data   out  MAX_READ  result, right-aligned, upper bits zero
//  out_vld   out  1         rd_data valid
//  out_rdy   in   1         consumer takes rd_data
//  bytes_cnt out  16        bytes accepted since reset (ANS_UNPACK_STATS_EN only)
// BEHAVIOUR
//  - Reset (async): buffer := 0, count := 0, rd_data := 0, out_vld := 0,
//    bytes_cnt := 0. byte_rdy therefore reads 1; rd_rdy reads 0.
//    An assertion mid-transfer discards all buffered bits and the pending result.
//  - Storage: buf[BUF_W-1:0], left-aligned. The valid bits are buf[BUF_W-1 -: count].
//    count is in 0..BUF_W and is (clog2(BUF_W)+1) bits wide.
//  - byte_rdy = en && (count <= BUF_W-8). It is combinational from registered state.
//    push = byte_vld && byte_rdy.
//  - rd_rdy = en && (count >= rd_len) && (!out_vld || out_rdy).
//    pop = rd_vld && rd_rdy.
//  - Pop, latency 1:
//    next cycle rd_data = buf[BUF_W-1 -: rd_len], zero-extended; out_vld = 1.
//    buf shifts left by rd_len, vacated LSBs are filled with 0.
//  - Push: the byte is written at buf[BUF_W-1-(count - (pop ? rd_len : 0)) -: 8],
//    i.e. directly after the surviving bits.
//  - Same-cycle push and pop are both permitted:
//    count_next = count + 8*push - rd_len*pop.
//    The push test uses the pre-pop count, so the buffer can never overflow.
//  - out_vld clears on out_rdy when no new pop occurs in that cycle.
//    A pop in the same cycle as out_rdy (back-to-back) keeps out_vld = 1
//    with the new data.
//  - Underflow: a request with count < rd_len stalls (rd_rdy = 0) until enough bytes arrive.
//  - rd_len = 0 or rd_len > MAX_READ is illegal. The design never asserts
//    rd_rdy for it; a bench assertion flags it.
//  - en = 0 freezes all state; byte_rdy = rd_rdy = 0; out_vld holds its value.
// CONFIGURATION
//  ANS_UNPACK_STATS_EN defined:
//    port bytes_cnt exists; it increments on every push and wraps 0xFFFF -> 0.
//  ANS_UNPACK_STATS_EN undefined:
//    port and counter are absent; all other behaviour is identical.
// STRUCTURE
//  - Shared ans_defs.vh holds: `SYM_WIDTH, the default MAX_READ/BUF_W constants,
//    and the ANS_UNPACK_STATS_EN switch.
//  - Single module, no sub-modules. The shift/insert network is inline
//    combinational logic feeding one register bank.
// TESTING
//  1. Reset, then push 0xA5 and request len 4 -> next cycle rd_data = 0x000A,
//     out_vld = 1. A second len-4 request returns 0x0005; count returns to 0.
//  2. Push 0xFF,0x00,0xFF,0x00 with no reads -> count = 32, byte_rdy = 0.
//     Pushing a 5th byte stalls until a len-8 read; that read returns 0x00FF.
//  3. Request len 12 with count = 8 -> rd_rdy stays 0.
//     Push 0x3C -> the read fires and returns the 12 bits in order.
//  4. Hold out_rdy = 0 with out_vld = 1 -> rd_rdy = 0 and rd_data is stable.
//     Raise out_rdy with a new request -> back-to-back result, no bubble.
//  5. Same-cycle push 0x81 and pop len 3 at count = 5 -> count = 10,
//     and the bit order is preserved.
//  6. Assert rst_n low mid-stream -> all outputs reach reset values immediately.
//     With STATS_EN: push 3 bytes -> bytes_cnt = 3.

Source files
------------

// File: rtl/ans_bit_unpacker_pkg.sv
// Shared constants for the ANS bit unpacker: default buffer geometry and a
// helper that decides whether a requested field length can be served.
package ans_bit_unpacker_pkg;

    localparam int DEF_BUF_W    = 32;
    localparam int DEF_MAX_READ = 16;
    localparam int DEF_LEN_W    = 5;

    // A field length is serviceable only when it is in 1..max_read.
    function automatic logic len_legal(input int unsigned len, input int unsigned max_read);
        return (len != 0) && (len <= max_read);
    endfunction

endpackage

// File: rtl/ans_bit_unpacker.sv
// ans_bit_unpacker: byte-in / variable-length-field-out bit buffer that feeds
// ans_decoder. Bytes are appended MSB-first behind the surviving bits of a
// left-aligned buffer; requests of 1..MAX_READ bits are served from the top.
// A result is registered one cycle after the request is accepted.
// Optional feature: define ANS_UNPACK_STATS_EN to add the bytes_cnt port and
// its 16-bit wrapping count of accepted bytes.
module ans_bit_unpacker
    import ans_bit_unpacker_pkg::*;
#(
    parameter int BUF_W    = DEF_BUF_W,
    parameter int MAX_READ = DEF_MAX_READ,
    parameter int LEN_W    = DEF_LEN_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [7:0]          byte_in,
    input  logic                byte_vld,
    output logic                byte_rdy,
    input  logic [LEN_W-1:0]    rd_len,
    input  logic                rd_vld,
    output logic                rd_rdy,
    output logic [MAX_READ-1:0] rd_data,
    output logic                out_vld,
    input  logic                out_rdy
`ifdef ANS_UNPACK_STATS_EN
    ,
    output logic [15:0]         bytes_cnt
`endif
);

    localparam int CNT_W = $clog2(BUF_W) + 1;

    // Top rd_len bits of the buffer, right-aligned and zero-extended.
    function automatic logic [MAX_READ-1:0] take_field(input logic [BUF_W-1:0] b,
                                                        input logic [CNT_W-1:0] len);
        logic [BUF_W-1:0] t;
        t = b >> (CNT_W'(BUF_W) - len);
        return t[MAX_READ-1:0];
    endfunction

    logic [BUF_W-1:0]    bits_p1;
    logic [CNT_W-1:0]    cnt_p1;
    logic [MAX_READ-1:0] data_p1;
    logic                vld_p1;

    logic [CNT_W-1:0]    len_c;
    logic                push;
    logic                pop;
    logic [CNT_W-1:0]    surv_c;
    logic [CNT_W-1:0]    cnt_next;
    logic [BUF_W-1:0]    bits_next;
    logic [BUF_W-1:0]    ins_c;

    assign len_c    = CNT_W'(rd_len);
    assign byte_rdy = en && (cnt_p1 <= CNT_W'(BUF_W - 8));
    assign rd_rdy   = en && len_legal(32'(rd_len), MAX_READ)
                         && (cnt_p1 >= len_c) && (!vld_p1 || out_rdy);
    assign push     = byte_vld && byte_rdy;
    assign pop      = rd_vld && rd_rdy;
    assign rd_data  = data_p1;
    assign out_vld  = vld_p1;

    // Shift out the popped field, then drop the new byte right behind the
    // bits that survive the pop. Push eligibility uses the pre-pop count.
    always_comb begin
        surv_c    = cnt_p1 - (pop ? len_c : '0);
        ins_c     = push ? ({byte_in, {(BUF_W-8){1'b0}}} >> surv_c) : '0;
        bits_next = (pop ? (bits_p1 << len_c) : bits_p1) | ins_c;
        cnt_next  = surv_c + (push ? CNT_W'(8) : '0);
    end

    // ---- stage p1: buffer fill level and result-valid flag ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p1 <= '0;
            vld_p1 <= 1'b0;
        end else if (en) begin
            cnt_p1 <= cnt_next;
            if (pop)
                vld_p1 <= 1'b1;
            else if (out_rdy)
                vld_p1 <= 1'b0;
        end
    end

    // Buffer contents and the registered result; a reset discards both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits_p1 <= '0;
            data_p1 <= '0;
        end else if (en) begin
            bits_p1 <= bits_next;
            if (pop)
                data_p1 <= take_field(bits_p1, len_c);
        end
    end

`ifdef ANS_UNPACK_STATS_EN
    // Running count of accepted bytes, wrapping at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bytes_cnt <= '0;
        else if (push)
            bytes_cnt <= bytes_cnt + 16'd1;
    end
`endif

endmodule
